// File: rtl/interrupter_sequencer.sv
// ---------------------------------------------------------------------------
// interrupter_sequencer
//
// Burst/interrupter controller for the coil drive. A runtime-programmable
// divider produces a slow tick; the FSM sequences alternating ON and OFF
// windows, each a whole number of ticks. New configuration is taken through
// a valid/ready handshake into a shadow copy and becomes active only when an
// ON window is entered, so a burst never sees a half-applied setting.
//
// Ports:
//   clock_in      in   1            rising-edge clock
//   reset         in   1            asynchronous active-low reset
//   enable        in   1            run request (level)
//   cfg_valid     in   1            configuration offer
//   cfg_ready     out  1            configuration accept (0 in reset, else 1)
//   cfg_divide    in   COUNT_WIDTH  tick period minus 1, in clocks
//   cfg_on_ticks  in   TICK_WIDTH   ON window length in ticks (0 = no bursts)
//   cfg_off_ticks in   TICK_WIDTH   OFF window length in ticks
//   tick_en       out  1            one-clock pulse per tick while running
//   gate          out  1            high during the ON window
//   burst_start   out  1            pulse on the first ON cycle
//   busy          out  1            FSM not idle
// ---------------------------------------------------------------------------
module interrupter_sequencer #(
    parameter int COUNT_WIDTH   = 32,
    parameter int TICK_WIDTH    = 16,
    parameter int MIN_OFF_TICKS = 4
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [COUNT_WIDTH-1:0] cfg_divide,
    input  logic [TICK_WIDTH-1:0]  cfg_on_ticks,
    input  logic [TICK_WIDTH-1:0]  cfg_off_ticks,
    output logic                   tick_en,
    output logic                   gate,
    output logic                   burst_start,
    output logic                   busy
);

    localparam logic [TICK_WIDTH-1:0] LP_MIN_OFF = TICK_WIDTH'(MIN_OFF_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // OFF length is clamped at use so a short programmed value cannot
    // starve the bridge of its recovery time.
    function automatic logic [TICK_WIDTH-1:0] f_off_eff(input logic [TICK_WIDTH-1:0] off);
        if (off < LP_MIN_OFF) begin
            return LP_MIN_OFF;
        end else begin
            return off;
        end
    endfunction

    state_t                   r_state;
    logic [COUNT_WIDTH-1:0]   r_div_cnt;
    logic [TICK_WIDTH-1:0]    r_tick_cnt;
    logic [COUNT_WIDTH-1:0]   r_act_div;
    logic [TICK_WIDTH-1:0]    r_act_on;
    logic [TICK_WIDTH-1:0]    r_act_off;
    logic [COUNT_WIDTH-1:0]   r_sh_div;
    logic [TICK_WIDTH-1:0]    r_sh_on;
    logic [TICK_WIDTH-1:0]    r_sh_off;
    logic                     r_pending;
    logic                     r_cfg_ready;
    logic                     r_tick_en;
    logic                     r_gate;
    logic                     r_burst_start;
    logic                     r_busy;

    state_t                   w_state_nxt;
    logic                     w_enter_on;
    logic                     w_enter_off;
    logic                     w_accept;
    logic [COUNT_WIDTH-1:0]   w_nxt_div;
    logic [TICK_WIDTH-1:0]    w_nxt_on;
    logic [TICK_WIDTH-1:0]    w_nxt_off;
    logic [TICK_WIDTH-1:0]    w_win_len;
    logic [TICK_WIDTH:0]      w_tick_sum;
    logic                     w_win_end;
    logic [COUNT_WIDTH-1:0]   w_div_cnt_nxt;
    logic [TICK_WIDTH-1:0]    w_tick_cnt_nxt;
    logic [COUNT_WIDTH-1:0]   w_act_div_nxt;
    logic                     w_tick_en_nxt;

    assign w_accept  = cfg_valid & r_cfg_ready;
    assign w_nxt_div = r_pending ? r_sh_div : r_act_div;
    assign w_nxt_on  = r_pending ? r_sh_on  : r_act_on;
    assign w_nxt_off = r_pending ? r_sh_off : r_act_off;

    // Window length and end-of-window detect. r_tick_en is exactly
    // "running and divider at terminal count" for the current cycle, so it
    // doubles as the internal tick strobe.
    always_comb begin
        w_win_len  = f_off_eff(r_act_off);
        w_tick_sum = {1'b0, r_tick_cnt} + (TICK_WIDTH+1)'(1'b1);
        if (r_state == ST_ON) begin
            w_win_len = r_act_on;
        end else begin
            w_win_len = f_off_eff(r_act_off);
        end
        w_win_end = r_tick_en && (w_tick_sum >= {1'b0, w_win_len});
    end

    // Next-state logic for the burst FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_enter_on  = 1'b0;
        w_enter_off = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && (w_nxt_on != '0)) begin
                    w_state_nxt = ST_ON;
                    w_enter_on  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ON: begin
                // A dropped enable truncates ON but still runs a full OFF.
                if (w_win_end || !enable) begin
                    w_state_nxt = ST_OFF;
                    w_enter_off = 1'b1;
                end else begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_OFF: begin
                if (w_win_end) begin
                    if (enable && (w_nxt_on != '0)) begin
                        w_state_nxt = ST_ON;
                        w_enter_on  = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_OFF;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next divider/tick counter values and the next-cycle tick strobe, so
    // tick_en can be driven from a flop.
    always_comb begin
        w_div_cnt_nxt  = '0;
        w_tick_cnt_nxt = '0;
        w_act_div_nxt  = r_act_div;
        if (w_enter_on) begin
            w_act_div_nxt = w_nxt_div;
        end else begin
            w_act_div_nxt = r_act_div;
        end
        if ((w_state_nxt == ST_IDLE) || w_enter_on || w_enter_off) begin
            w_div_cnt_nxt  = '0;
            w_tick_cnt_nxt = '0;
        end else if (r_tick_en) begin
            w_div_cnt_nxt  = '0;
            w_tick_cnt_nxt = w_tick_sum[TICK_WIDTH-1:0];
        end else begin
            w_div_cnt_nxt  = r_div_cnt + COUNT_WIDTH'(1'b1);
            w_tick_cnt_nxt = r_tick_cnt;
        end
        w_tick_en_nxt = (w_state_nxt != ST_IDLE) && (w_div_cnt_nxt >= w_act_div_nxt);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_div_cnt     <= '0;
            r_tick_cnt    <= '0;
            r_tick_en     <= 1'b0;
            r_gate        <= 1'b0;
            r_burst_start <= 1'b0;
            r_busy        <= 1'b0;
            r_cfg_ready   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_div_cnt     <= w_div_cnt_nxt;
            r_tick_cnt    <= w_tick_cnt_nxt;
            r_tick_en     <= w_tick_en_nxt;
            r_gate        <= (w_state_nxt == ST_ON);
            r_burst_start <= w_enter_on;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_cfg_ready   <= 1'b1;
        end
    end

    // Shadow/active configuration. An accept coinciding with an ON entry
    // lands in the shadow and stays pending for the following entry.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_act_div <= '0;
            r_act_on  <= '0;
            r_act_off <= LP_MIN_OFF;
            r_sh_div  <= '0;
            r_sh_on   <= '0;
            r_sh_off  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_enter_on) begin
                r_act_div <= w_nxt_div;
                r_act_on  <= w_nxt_on;
                r_act_off <= w_nxt_off;
            end
            if (w_accept) begin
                r_sh_div  <= cfg_divide;
                r_sh_on   <= cfg_on_ticks;
                r_sh_off  <= cfg_off_ticks;
                r_pending <= 1'b1;
            end else if (w_enter_on) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign tick_en     = r_tick_en;
    assign gate        = r_gate;
    assign burst_start = r_burst_start;
    assign busy        = r_busy;

endmodule
